// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: datapath width, opcodes, response payload.
// Latency: n/a (types only). Backpressure: n/a.
package alu_share_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: add/sub/logic/slt/logical shifts with a zero flag.
// Latency: combinational. Backpressure: none.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic            is_add;
  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum;
  logic            ovf;
  logic            slt;

  // Everything except add goes through a + ~b + 1 so slt can reuse the subtractor.
  assign is_add = (alucontrol == ALU_ADD);
  assign b_eff  = is_add ? b : ~b;
  assign sum    = a + b_eff + XLEN'(!is_add);
  assign ovf    = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign slt    = sum[XLEN-1] ^ ovf;

  always_comb begin
    result = '0;
    case (alu_op_e'(alucontrol))
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, slt};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first valid requester after 'last', wrapping around.
// Latency: combinational. Backpressure: en=0 suppresses every grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

  // Two ordered passes: indices above 'last' first, then the wrap-around part.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i > int'(last))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i <= int'(last))) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters with a single registered, owner-tagged response.
// Latency: 1 cycle accept-to-rsp_valid. Backpressure: held response with rsp_ready=0 blocks all grants.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*3-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic [IDW-1:0]       rsp_owner
);

  logic            rsp_vld_q, rsp_vld_d;
  alu_rsp_t        rsp_dat_q, rsp_dat_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;

  logic            out_open;
  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic [2:0]      alu_op;
  logic            alu_zero;

  // Reset gates the arbiter so req_ready stays low while reset is asserted.
  assign out_open = ~rsp_vld_q | rsp_ready;
  assign arb_en   = out_open & reset;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .last    (last_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_a  = req_a[i*XLEN +: XLEN];
        alu_b  = req_b[i*XLEN +: XLEN];
        alu_op = req_op[i*3 +: 3];
      end
    end
  end

  alu u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .alucontrol (alu_op),
    .result     (alu_y),
    .zero       (alu_zero)
  );

  // A retire with no new grant clears valid but keeps the data fields.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    rsp_dat_d = rsp_dat_q;
    owner_d   = owner_q;
    last_d    = last_q;
    if (|gnt) begin
      rsp_vld_d        = 1'b1;
      rsp_dat_d.result = alu_y;
      rsp_dat_d.zero   = alu_zero;
      owner_d          = gnt_idx;
      last_d           = gnt_idx;
    end else if (rsp_ready) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      owner_q   <= '0;
      last_q    <= IDW'(NREQ-1);
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

  assign rsp_valid  = rsp_vld_q;
  assign rsp_result = rsp_dat_q.result;
  assign rsp_zero   = rsp_dat_q.zero;
  assign rsp_owner  = owner_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed checks on a 2-requester instance plus a randomized fairness sweep on a 4-requester instance.
// Inputs change on the falling edge; outputs are sampled 1ns later or on the next falling edge.
module tb_alu_share_arbiter;

  logic clk;
  logic reset;

  logic [1:0]   v2, rdy2;
  logic [63:0]  a2, b2;
  logic [5:0]   op2;
  logic         rr2, rv2, z2;
  logic [31:0]  res2;
  logic [2:0]   own2;

  logic [3:0]   v4, rdy4;
  logic [127:0] a4, b4;
  logic [11:0]  op4;
  logic         rr4, rv4, z4;
  logic [31:0]  res4;
  logic [1:0]   own4;

  int n_cmp;
  int n_err;

  alu_share_arbiter #(.NREQ(2), .IDW(3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_a(a2), .req_b(b2),
    .req_op(op2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_result(res2), .rsp_zero(z2), .rsp_owner(own2)
  );

  alu_share_arbiter #(.NREQ(4), .IDW(2)) dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4), .req_a(a4), .req_b(b4),
    .req_op(op4), .rsp_valid(rv4), .rsp_ready(rr4), .rsp_result(res4), .rsp_zero(z4), .rsp_owner(own4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: alu_ref = a + b;
      3'd1: alu_ref = a - b;
      3'd2: alu_ref = a & b;
      3'd3: alu_ref = a | b;
      3'd4: alu_ref = a ^ b;
      3'd5: alu_ref = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: alu_ref = a << b[4:0];
      default: alu_ref = a >> b[4:0];
    endcase
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    v2 = 2'b11;
    #1;
    n_cmp++; if (rdy2 !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", rdy2); end
    n_cmp++; if (rv2 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rv2); end
    n_cmp++; if (res2 !== 32'd0 || z2 !== 1'b0 || own2 !== 3'd0) begin
      n_err++; $display("FAIL reset_fields got res=%h z=%b own=%0d exp 0/0/0", res2, z2, own2);
    end
    @(negedge clk);
    reset = 1'b1;
    v2    = 2'b00;
    #1;
    n_cmp++; if (rdy2 !== 2'b00 || rv2 !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got rdy=%b vld=%b exp 00/0", rdy2, rv2);
    end
    a2[31:0] = 32'd5; b2[31:0] = 32'd7; op2[2:0] = 3'b000; v2 = 2'b01;
    #1;
    n_cmp++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL first_grant got=%b exp=01", rdy2); end
    @(negedge clk);
    v2 = 2'b00;
    n_cmp++; if (rv2 !== 1'b1 || res2 !== 32'd12 || z2 !== 1'b0 || own2 !== 3'd0) begin
      n_err++; $display("FAIL add_rsp got vld=%b res=%0d z=%b own=%0d exp 1/12/0/0", rv2, res2, z2, own2);
    end
  endtask

  task automatic test_contention;
    apply_reset();
    rr2 = 1'b1;
    a2  = {32'hFFFF_FFFF, 32'd9};
    b2  = {32'd1, 32'd9};
    op2 = {3'b101, 3'b001};
    v2  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (rdy2 !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contention_grant k=%0d got=%b", k, rdy2);
      end
      @(negedge clk);
      n_cmp++; if (rv2 !== 1'b1 || own2 !== 3'(k % 2) || res2 !== ((k % 2 == 1) ? 32'd1 : 32'd0) ||
                   z2 !== ((k % 2 == 1) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL contention_rsp k=%0d got vld=%b own=%0d res=%h z=%b", k, rv2, own2, res2, z2);
      end
    end
  endtask

  task automatic test_backpressure;
    rr2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (rdy2 !== 2'b00) begin n_err++; $display("FAIL bp_ready k=%0d got=%b exp=00", k, rdy2); end
      n_cmp++; if (rv2 !== 1'b1 || res2 !== 32'd1 || own2 !== 3'd1 || z2 !== 1'b0) begin
        n_err++; $display("FAIL bp_hold k=%0d got vld=%b res=%h own=%0d z=%b exp 1/1/1/0", k, rv2, res2, own2, z2);
      end
      @(negedge clk);
    end
    rr2 = 1'b1;
    #1;
    n_cmp++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL bp_release_grant got=%b exp=01", rdy2); end
    @(negedge clk);
    n_cmp++; if (rv2 !== 1'b1 || own2 !== 3'd0 || res2 !== 32'd0 || z2 !== 1'b1) begin
      n_err++; $display("FAIL bp_release_rsp got vld=%b own=%0d res=%h z=%b exp 1/0/0/1", rv2, own2, res2, z2);
    end
  endtask

  task automatic test_back_to_back;
    v2 = 2'b10;
    a2[63:32] = 32'd1; b2[63:32] = 32'd31; op2[5:3] = 3'b110;
    #1;
    n_cmp++; if (rdy2 !== 2'b10) begin n_err++; $display("FAIL b2b_grant0 got=%b exp=10", rdy2); end
    @(negedge clk);
    n_cmp++; if (rv2 !== 1'b1 || res2 !== 32'h8000_0000 || own2 !== 3'd1) begin
      n_err++; $display("FAIL b2b_sll got vld=%b res=%h own=%0d exp 1/80000000/1", rv2, res2, own2);
    end
    a2[63:32] = 32'h8000_0000; op2[5:3] = 3'b111;
    #1;
    n_cmp++; if (rdy2 !== 2'b10) begin n_err++; $display("FAIL b2b_grant1 got=%b exp=10", rdy2); end
    @(negedge clk);
    n_cmp++; if (rv2 !== 1'b1 || res2 !== 32'd1 || own2 !== 3'd1 || z2 !== 1'b0) begin
      n_err++; $display("FAIL b2b_srl got vld=%b res=%h own=%0d z=%b exp 1/1/1/0", rv2, res2, own2, z2);
    end
  endtask

  task automatic test_reset_midflight;
    rr2 = 1'b0;
    v2  = 2'b11;
    #1;
    n_cmp++; if (rv2 !== 1'b1 || rdy2 !== 2'b00) begin
      n_err++; $display("FAIL mid_pre got vld=%b rdy=%b exp 1/00", rv2, rdy2);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (rv2 !== 1'b0 || rdy2 !== 2'b00) begin
      n_err++; $display("FAIL mid_async got vld=%b rdy=%b exp 0/00", rv2, rdy2);
    end
    n_cmp++; if (res2 !== 32'd0 || own2 !== 3'd0 || z2 !== 1'b0) begin
      n_err++; $display("FAIL mid_fields got res=%h own=%0d z=%b exp 0/0/0", res2, own2, z2);
    end
    @(negedge clk);
    reset = 1'b1;
    rr2   = 1'b1;
    #1;
    n_cmp++; if (rdy2 !== 2'b01) begin n_err++; $display("FAIL mid_first_grant got=%b exp=01", rdy2); end
    @(negedge clk);
    v2 = 2'b00;
    n_cmp++; if (rv2 !== 1'b1 || own2 !== 3'd0 || z2 !== 1'b1) begin
      n_err++; $display("FAIL mid_rsp got vld=%b own=%0d z=%b exp 1/0/1", rv2, own2, z2);
    end
  endtask

  task automatic test_fairness;
    logic [3:0]  pend;
    int          wait_cnt[4];
    logic [31:0] ma[4], mb[4];
    logic [2:0]  mop[4];
    logic        m_vld;
    logic [31:0] m_res;
    logic [1:0]  m_own, m_last;
    logic [3:0]  exp_gnt;
    int          g;
    apply_reset();
    pend = '0; m_vld = 1'b0; m_res = '0; m_own = '0; m_last = 2'd3;
    for (int i = 0; i < 4; i++) begin
      wait_cnt[i] = 0; ma[i] = '0; mb[i] = '0; mop[i] = '0;
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      n_cmp++; if (rv4 !== m_vld) begin n_err++; $display("FAIL fair_valid cyc=%0d got=%b exp=%b", cyc, rv4, m_vld); end
      if (m_vld) begin
        n_cmp++; if (res4 !== m_res || z4 !== (m_res == 32'd0) || own4 !== m_own) begin
          n_err++; $display("FAIL fair_rsp cyc=%0d got res=%h z=%b own=%0d exp res=%h own=%0d", cyc, res4, z4, own4, m_res, m_own);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          wait_cnt[i] = 0;
          ma[i]  = $urandom;
          mb[i]  = ($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(40, 0);
          mop[i] = 3'($urandom_range(7, 0));
        end
        a4[i*32 +: 32] = ma[i];
        b4[i*32 +: 32] = mb[i];
        op4[i*3 +: 3]  = mop[i];
      end
      v4  = pend;
      rr4 = ($urandom_range(3, 0) != 0);
      #1;
      g = -1;
      if (!m_vld || rr4) begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (int'(m_last) + k) % 4;
          if (g < 0 && pend[j]) g = j;
        end
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      n_cmp++; if (rdy4 !== exp_gnt) begin n_err++; $display("FAIL fair_grant cyc=%0d got=%b exp=%b", cyc, rdy4, exp_gnt); end
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_res  = alu_ref(ma[g], mb[g], mop[g]);
        m_own  = 2'(g);
        m_last = 2'(g);
        pend[g] = 1'b0;
        n_cmp++; if (wait_cnt[g] > 3) begin n_err++; $display("FAIL fair_wait cyc=%0d req=%0d got=%0d exp<=3", cyc, g, wait_cnt[g]); end
        for (int i = 0; i < 4; i++) if (pend[i]) wait_cnt[i]++;
      end else if (rr4) begin
        m_vld = 1'b0;
      end
      @(negedge clk);
    end
    v4 = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    v2 = '0; a2 = '0; b2 = '0; op2 = '0; rr2 = 1'b1;
    v4 = '0; a4 = '0; b4 = '0; op4 = '0; rr4 = 1'b1;
    test_reset();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
